// File: rtl/l1_icache_nway.sv
// ---------------------------------------------------------------------------
// l1_icache_nway: N-way set-associative L1 instruction cache, 256-bit lines.
//
// Lookup is purely combinational: hit, o and fault follow adr in the same
// cycle. A miss on req in IDLE starts a two-beat line fill from L2
// (MISS -> FILL1 -> WRITE -> IDLE). The line is written in WRITE and hits
// from the following cycle.
//
// Configuration macro:
//   ICACHE_PLRU_EN  defined   -> per-set tree pseudo-LRU replacement
//                   undefined -> low bits of a free-running 16-bit LFSR
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req, adr         fetch request and address (adr[4] selects line half)
//   o, fault, hit    selected 128-bit half, stored {err,exv}, tag hit
//   busy             FSM not in IDLE
//   miss_req         line-fill request to L2
//   miss_adr         line-aligned fill address
//   fill_vld         fill beat valid
//   fill_dat         fill beat data (beat 0 = line[127:0], beat 1 = line[255:128])
//   fill_err         bus error on the beat
//   fill_exv         execute violation on the beat
//   invall           invalidate every line
//   invline          invalidate the line hit by adr
// ---------------------------------------------------------------------------
module l1_icache_nway #(
    parameter int unsigned WAYS = 4,
    parameter int unsigned SETS = 32,
    parameter int unsigned AMSB = 79
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic [AMSB:0] adr,
    output logic [127:0]  o,
    output logic [1:0]    fault,
    output logic          hit,
    output logic          busy,
    output logic          miss_req,
    output logic [AMSB:0] miss_adr,
    input  logic          fill_vld,
    input  logic [127:0]  fill_dat,
    input  logic          fill_err,
    input  logic          fill_exv,
    input  logic          invall,
    input  logic          invline
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned WAY_W = $clog2(WAYS);
    localparam int unsigned TAG_W = AMSB - 4;

    typedef enum logic [1:0] {StIdle, StMiss, StFill1, StWrite} state_e;

    // Storage: tag/data RAMs are not reset, only the valid bits are.
    // Data word layout: {err, exv, beat1, beat0}.
    logic [TAG_W-1:0] tag_ram  [WAYS][SETS];
    logic [257:0]     data_ram [WAYS][SETS];
    logic [SETS-1:0]  valid_q  [WAYS];

    state_e           state_q;
    logic             miss_req_q;
    logic             busy_q;
    logic [AMSB:0]    miss_adr_q;
    logic [WAY_W-1:0] victim_q;
    logic             abort_q;
    logic [127:0]     beat0_q;
    logic [127:0]     beat1_q;
    logic             err_q;
    logic             exv_q;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] widx;
    logic [WAYS-1:0]  hit_vec;
    logic [WAY_W-1:0] repl_way;
    logic [WAY_W-1:0] victim_sel;
    logic             victim_found;
    logic             miss_line_match;
    logic             inv_pending;
    logic             start_miss;
    logic             wr_en;
    logic             unused_adr;

    assign idx        = adr[IDX_W+4:5];
    assign tag        = adr[AMSB:5];
    assign widx       = miss_adr_q[IDX_W+4:5];
    assign unused_adr = ^adr[3:0];

    // ---------------------------------------------------------------- lookup
    always_comb begin
        hit_vec = '0;
        o       = '0;
        fault   = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (valid_q[w][idx] && (tag_ram[w][idx] == tag)) begin
                hit_vec[w] = 1'b1;
                o     = o | (adr[4] ? data_ram[w][idx][255:128] : data_ram[w][idx][127:0]);
                fault = fault | data_ram[w][idx][257:256];
            end
        end
    end

    assign hit = |hit_vec;

    // Lowest invalid way first, otherwise the replacement policy decides.
    always_comb begin
        victim_sel   = repl_way;
        victim_found = 1'b0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (!victim_found && !valid_q[w][idx]) begin
                victim_sel   = WAY_W'(w);
                victim_found = 1'b1;
            end
        end
    end

    // ------------------------------------------------------- control decode
    assign miss_line_match = (tag == miss_adr_q[AMSB:5]);
    // Anything that must stop the outstanding fill from landing in the RAM.
    assign inv_pending     = invall || (invline && miss_line_match);
    assign start_miss      = (state_q == StIdle) && req && !hit && !invall && !invline;
    // Same-cycle invalidation in WRITE also suppresses the write.
    assign wr_en           = (state_q == StWrite) && !abort_q && !inv_pending;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            miss_req_q <= 1'b0;
            busy_q     <= 1'b0;
            miss_adr_q <= '0;
            victim_q   <= '0;
            abort_q    <= 1'b0;
            beat0_q    <= '0;
            beat1_q    <= '0;
            err_q      <= 1'b0;
            exv_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_miss) begin
                        state_q    <= StMiss;
                        miss_req_q <= 1'b1;
                        busy_q     <= 1'b1;
                        miss_adr_q <= {adr[AMSB:5], 5'b0};
                        victim_q   <= victim_sel;
                        abort_q    <= 1'b0;
                    end
                end
                StMiss: begin
                    if (fill_vld) begin
                        beat0_q <= fill_dat;
                        err_q   <= fill_err;
                        exv_q   <= fill_exv;
                        state_q <= StFill1;
                    end
                end
                StFill1: begin
                    if (fill_vld) begin
                        beat1_q    <= fill_dat;
                        err_q      <= err_q | fill_err;
                        exv_q      <= exv_q | fill_exv;
                        state_q    <= StWrite;
                        miss_req_q <= 1'b0;
                    end
                end
                StWrite: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= StIdle;
                    miss_req_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
            // Fill keeps running to consume its beats, but will not be written.
            if ((state_q != StIdle) && inv_pending) begin
                abort_q <= 1'b1;
            end
        end
    end

    assign miss_req = miss_req_q;
    assign busy     = busy_q;
    assign miss_adr = miss_adr_q;

    // ------------------------------------------------------------ RAM write
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_ram[victim_q][widx]  <= miss_adr_q[AMSB:5];
            data_ram[victim_q][widx] <= {err_q, exv_q, beat1_q, beat0_q};
        end
    end

    // ----------------------------------------------------------- valid bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < int'(WAYS); w++) begin
                valid_q[w] <= '0;
            end
        end else if (invall) begin
            for (int w = 0; w < int'(WAYS); w++) begin
                valid_q[w] <= '0;
            end
        end else begin
            if (invline) begin
                for (int w = 0; w < int'(WAYS); w++) begin
                    if (hit_vec[w]) begin
                        valid_q[w][idx] <= 1'b0;
                    end
                end
            end
            if (wr_en) begin
                valid_q[victim_q][widx] <= 1'b1;
            end
        end
    end

    // ----------------------------------------------------------- replacement
`ifdef ICACHE_PLRU_EN
    // Tree PLRU, heap-ordered: node n (1-based) is bit n-1, children 2n and
    // 2n+1. A bit of 0 points left (lower ways), 1 points right.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] t);
        int unsigned node;
        node = 1;
        for (int l = 0; l < int'(WAY_W); l++) begin
            node = 32'd2 * node + (t[node-1] ? 32'd1 : 32'd0);
        end
        return WAY_W'(node - WAYS);
    endfunction

    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] t,
                                                   input logic [WAY_W-1:0] way);
        logic [WAYS-2:0] r;
        int unsigned     node;
        logic            b;
        r    = t;
        node = 1;
        for (int l = 0; l < int'(WAY_W); l++) begin
            b         = way[WAY_W-1-l];
            r[node-1] = ~b;
            node      = 32'd2 * node + (b ? 32'd1 : 32'd0);
        end
        return r;
    endfunction

    logic [WAYS-2:0]  plru_q [SETS];
    logic [WAYS-2:0]  plru_d [SETS];
    logic [WAY_W-1:0] hit_way;

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (hit_vec[w]) begin
                hit_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        plru_d = plru_q;
        if (req && hit) begin
            plru_d[idx] = plru_touch(plru_d[idx], hit_way);
        end
        if (wr_en) begin
            plru_d[widx] = plru_touch(plru_d[widx], victim_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < int'(SETS); s++) begin
                plru_q[s] <= '0;
            end
        end else begin
            plru_q <= plru_d;
        end
    end

    assign repl_way = plru_victim(plru_q[idx]);
`else
    // x^16 + x^14 + x^13 + x^11 Fibonacci LFSR, steps every cycle.
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign repl_way = lfsr_q[WAY_W-1:0];
`endif

endmodule

// File: doc/l1_icache_nway.md
L1_ICACHE_NWAY -- requirements
Module: l1_icache_nway

Interface
REQ-001 SHALL have parameter WAYS, default 4: associativity, legal values 2, 4, 8.
REQ-002 SHALL have parameter SETS, default 32: sets per way, power of two, 16..256.
REQ-003 SHALL have parameter AMSB, default 79: MSB of the address bus.
REQ-004 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port req  in  1  fetch request, qualifies adr.
REQ-007 SHALL have port adr  in  AMSB+1  fetch address; adr[4] selects the 128-bit half of a 256-bit line.
REQ-008 SHALL have port o  out  128  selected line half; valid when hit=1.
REQ-009 SHALL have port fault  out  2  {err,exv} fault bits stored with the hit line.
REQ-010 SHALL have port hit  out  1  combinational tag hit for adr.
REQ-011 SHALL have port busy  out  1  high whenever the FSM is not in IDLE.
REQ-012 SHALL have port miss_req  out  1  line-fill request to L2.
REQ-013 SHALL have port miss_adr  out  AMSB+1  line-aligned fill address, bits [4:0]=0.
REQ-014 SHALL have port fill_vld  in  1  fill beat valid.
REQ-015 SHALL have port fill_dat  in  128  fill beat data; beat 0 = bits 127:0, beat 1 = bits 255:128.
REQ-016 SHALL have port fill_err  in  1  bus error on the beat.
REQ-017 SHALL have port fill_exv  in  1  execute violation on the beat.
REQ-018 SHALL have port invall  in  1  invalidate all lines.
REQ-019 SHALL have port invline  in  1  invalidate the line matching adr.

Function
REQ-020 Set index SHALL be adr[log2(SETS)+4:5]; tag SHALL be adr[AMSB:5]; a way hits when its tag matches and its valid bit is set.
REQ-021 hit, o and fault SHALL be combinational from adr in the same cycle, with zero-cycle read latency.
REQ-022 The FSM SHALL have states IDLE, MISS, FILL1 and WRITE.
REQ-023 IDLE->MISS SHALL occur when req=1, hit=0, invall=0 and invline=0; on entry it latches miss_adr and the victim way.
REQ-024 MISS SHALL hold miss_req=1; fill_vld SHALL capture beat 0 and move to FILL1.
REQ-025 FILL1 SHALL hold miss_req=1; fill_vld SHALL capture beat 1 and move to WRITE.
REQ-026 WRITE SHALL write the tag, the 258-bit data line and the valid bit, deassert miss_req, and return to IDLE. A fetch of the filled line hits on the cycle after WRITE; miss latency is 3 cycles plus L2 beat delays.
REQ-027 Stored fault SHALL be {err0|err1, exv0|exv1} over both beats.
REQ-028 Victim selection SHALL pick the lowest-index invalid way in the set; if all ways are valid, the replacement policy (REQ-039/040) picks the way.
REQ-029 req with a miss while busy=1 SHALL be ignored; the requester retries.
REQ-030 invall SHALL clear every valid bit in one cycle in any state; if busy, the pending WRITE SHALL be suppressed (abort flag) and the FSM still consumes the remaining beats.
REQ-031 invline SHALL clear the valid bit of the hitting way of adr in any state; if adr's line equals miss_adr during a fill, the pending WRITE SHALL be suppressed.
REQ-032 invall and invline in the same cycle SHALL act as invall.
REQ-033 fill_vld in IDLE or WRITE SHALL be ignored.

Reset
REQ-034 On rst_n=0 the FSM SHALL go to IDLE asynchronously.
REQ-035 On rst_n=0 all valid bits, the abort flag and the replacement state SHALL clear; the LFSR SHALL load seed 16'hACE1.
REQ-036 On rst_n=0 miss_req=0, busy=0, miss_adr=0 and hit=0.
REQ-037 Tag and data RAMs SHALL NOT be reset.
REQ-038 Reset mid-fill SHALL abandon the fill without any RAM write.

Configuration
REQ-039 With ICACHE_PLRU_EN defined, replacement SHALL be per-set tree pseudo-LRU (WAYS-1 bits per set), updated on each req&&hit and on each WRITE, pointing away from the accessed way.
REQ-040 With ICACHE_PLRU_EN undefined, replacement SHALL use the low log2(WAYS) bits of a free-running 16-bit LFSR that advances every cycle, and no PLRU storage SHALL exist.

Verification
REQ-041 Cold miss: after reset, req with adr=0x1000, L2 returns beats A,B with 1-cycle gaps -> miss_req=1 with miss_adr=0x1000, line written, hit=1 with o=A at 0x1000 and o=B at 0x1010.
REQ-042 Fault merge: fill_err on beat 1 only -> fault=2'b10 on both halves of the line.
REQ-043 invall during FILL1 -> fill completes, busy drops, and a later req to the same line misses again.
REQ-044 Fill set 3 with WAYS+1 distinct tags, PLRU enabled, after touching ways 0..WAYS-1 in order -> way 0 evicted; other ways still hit.
REQ-045 rst_n low in MISS -> miss_req=0 and busy=0 immediately; the line is not valid afterwards.
REQ-046 invline on a hit line in IDLE -> hit=0 next cycle; other ways of the same set still hit.
